// File: rtl/conversor_binario_bcd_seq_if.sv
// rtl/conversor_binario_bcd_seq_if.sv - start/busy/done handshake bundle for the binary-to-BCD converter
interface conversor_binario_bcd_seq_if #(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 2
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  // requester side: issues operands and watches for the result
  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out,
    input  overflow
  );

  // converter side
  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out,
    output overflow
  );
endinterface

// File: rtl/conversor_binario_bcd_seq.sv
// rtl/conversor_binario_bcd_seq.sv - sequential double-dabble binary-to-BCD converter with saturation
module conversor_binario_bcd_seq #(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  conversor_binario_bcd_seq_if.slave   bus
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // largest value the digit field can show; anything above saturates to all nines
  localparam int MAX = pow10(DIGITS) - 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [SCR_W-1:0] NINES    = {DIGITS{4'h9}};

  logic [1:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic [BIN_W-1:0]        operand;
  logic [SCR_W-1:0]        scratch;
  logic [SCR_W-1:0]        scratch_adj;
  logic [SCR_W+BIN_W-1:0]  shifted;
  logic                    ovf_pend;
  logic [31:0]             bin_ext;
  logic                    accept;

  logic                    busy_r;
  logic                    done_r;
  logic                    ovf_r;
  logic [SCR_W-1:0]        bcd_r;

  assign accept  = (state == IDLE) && bus.start;
  assign bin_ext = 32'(bus.bin_in);

  // add-3 correction on every nibble that would reach 10 or more after doubling
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // the bit leaving the top of the scratch is dropped; it only exists for saturating inputs
  assign shifted = {scratch_adj, operand} << 1;

  // control FSM: IDLE -> SHIFT (BIN_W cycles) -> FINISH (1 cycle) -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= SHIFT;
            cnt   <= CNT_LOAD;
          end
        end
        SHIFT: begin
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) state <= FINISH;
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // datapath: operand/scratch shift register and pending-overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand  <= '0;
      scratch  <= '0;
      ovf_pend <= 1'b0;
    end else if (accept) begin
      operand  <= bus.bin_in;
      scratch  <= '0;
      ovf_pend <= (bin_ext > 32'(MAX));
    end else if (state == SHIFT) begin
      {scratch, operand} <= shifted;
    end
  end

  // registered outputs: result and overflow only move on the FINISH edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
      bcd_r  <= '0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        busy_r <= 1'b1;
      end else if (state == FINISH) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
        ovf_r  <= ovf_pend;
        bcd_r  <= ovf_pend ? NINES : scratch;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.overflow = ovf_r;
  assign bus.bcd_out  = bcd_r;

endmodule
